// File: rtl/cds_pkg.sv
// Shared types and helpers for the countdown_seconds block.
//   cds_state_t : countdown FSM states
//   BCD_W       : width of one BCD digit
//   BCD_MAX     : largest legal BCD digit
//   bcd_clamp() : saturate an out-of-range digit to 9
//   bcd2bin()   : two BCD digits -> binary 0..99
package cds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } cds_state_t;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [BCD_W-1:0] tens,
                                           input logic [BCD_W-1:0] ones);
        return (7'(tens) * 7'd10) + 7'(ones);
    endfunction

endpackage

// File: rtl/bcd2_down.sv
// Two-digit BCD down-counter register.
//   i_clk, i_rst            : clock, async active-high reset
//   i_load                  : load (clamped) digits; wins over i_dec
//   i_load_tens/i_load_ones : value to load, digits > 9 clamp to 9
//   i_dec                   : decrement by one with borrow, holds at 00
//   o_tens/o_ones           : registered current value
//   o_next_tens/o_next_ones : value that will be registered on this edge
//   o_zero                  : next value is 00
module bcd2_down
    import cds_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_tens,
    input  logic [BCD_W-1:0] i_load_ones,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones,
    output logic [BCD_W-1:0] o_next_tens,
    output logic [BCD_W-1:0] o_next_ones,
    output logic             o_zero
);

    logic [BCD_W-1:0] r_tens, r_ones;
    logic [BCD_W-1:0] w_nt, w_no;
    logic             w_is_zero;

    assign w_is_zero = (r_tens == '0) && (r_ones == '0);

    always_comb begin
        w_nt = r_tens;
        w_no = r_ones;
        if (i_load) begin
            w_nt = bcd_clamp(i_load_tens);
            w_no = bcd_clamp(i_load_ones);
        end else if (i_dec && !w_is_zero) begin
            // 00 is a floor: never borrow below it
            if (r_ones == '0) begin
                w_no = BCD_MAX;
                w_nt = r_tens - 4'd1;
            end else begin
                w_no = r_ones - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else begin
            r_tens <= w_nt;
            r_ones <= w_no;
        end
    end

    assign o_tens      = r_tens;
    assign o_ones      = r_ones;
    assign o_next_tens = w_nt;
    assign o_next_ones = w_no;
    assign o_zero      = (w_nt == '0) && (w_no == '0);

endmodule

// File: rtl/countdown_seconds.sv
// Seconds countdown driven by a 1 ms tick. Counts MS_PER_SEC ticks per
// second, decrements a two-digit BCD value and pulses done on reaching 00.
// Optional feature macro: CDS_WARN_EN adds the registered warn output.
//   clk, rst            : clock, async active-high reset
//   ms_tick             : 1 ms pulse from upstream timer
//   start               : load digits and begin (any state)
//   pause               : level, hold countdown while high
//   load_tens/load_ones : BCD start value, digits > 9 clamp to 9
//   timer_enable        : upstream timer enable, high only in RUN (comb.)
//   sec_tens/sec_ones   : remaining seconds, BCD
//   running             : high in RUN
//   done                : one-cycle expiry pulse
//   warn                : remaining <= WARN_SECS in RUN/PAUSED (CDS_WARN_EN)
module countdown_seconds
    import cds_pkg::*;
#(
    parameter int MS_PER_SEC = 1000,
    parameter int MS_W       = 10,
    parameter int WARN_SECS  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ms_tick,
    input  logic             start,
    input  logic             pause,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_ones,
    output logic             timer_enable,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             done
`ifdef CDS_WARN_EN
   ,output logic             warn
`endif
);

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);

    cds_state_t       r_state, w_state_next;
    logic [MS_W-1:0]  r_ms_count, w_ms_next;
    logic             r_running, r_done;
    logic             w_load, w_dec, w_zero, w_done_next;
    logic [BCD_W-1:0] w_next_tens, w_next_ones;

    bcd2_down u_bcd (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (w_load),
        .i_load_tens (load_tens),
        .i_load_ones (load_ones),
        .i_dec       (w_dec),
        .o_tens      (sec_tens),
        .o_ones      (sec_ones),
        .o_next_tens (w_next_tens),
        .o_next_ones (w_next_ones),
        .o_zero      (w_zero)
    );

    // Next state: start beats tick processing, which beats pause.
    always_comb begin
        w_state_next = r_state;
        w_ms_next    = r_ms_count;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_done_next  = 1'b0;
        if (start) begin
            w_load    = 1'b1;
            w_ms_next = '0;
            if (w_zero) begin
                w_state_next = ST_EXPIRED;
                w_done_next  = 1'b1;
            end else begin
                w_state_next = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ms_tick && (r_ms_count == MS_LAST)) begin
                        w_ms_next = '0;
                        w_dec     = 1'b1;
                    end else if (ms_tick) begin
                        w_ms_next = r_ms_count + 1'b1;
                    end
                    // expiry from the counted tick overrides a same-cycle pause
                    if (w_dec && w_zero) begin
                        w_state_next = ST_EXPIRED;
                        w_done_next  = 1'b1;
                    end else if (pause) begin
                        w_state_next = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) w_state_next = ST_RUN;
                end
                default: ;  // IDLE / EXPIRED hold until start
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ms_count <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ms_count <= w_ms_next;
            r_running  <= (w_state_next == ST_RUN);
            r_done     <= w_done_next;
        end
    end

    assign timer_enable = (r_state == ST_RUN);
    assign running      = r_running;
    assign done         = r_done;

`ifdef CDS_WARN_EN
    logic r_warn;
    logic w_warn_next;

    // Registered from the next value/state so warn lines up with the digits.
    assign w_warn_next = ((w_state_next == ST_RUN) || (w_state_next == ST_PAUSED)) &&
                         (bcd2bin(w_next_tens, w_next_ones) <= 7'(WARN_SECS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_warn <= 1'b0;
        else     r_warn <= w_warn_next;
    end

    assign warn = r_warn;
`else
    logic w_unused_next;
    assign w_unused_next = ^{w_next_tens, w_next_ones};
`endif

endmodule
